// File: rtl/uart_tx_sched.sv
// uart_tx_sched: round-robin scheduler of 1/2-byte frames from two requesters onto one UART transmitter
module uart_tx_sched #(
  parameter logic [15:0] BAUD_RST = 16'd868
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req0,
  input  logic        req1,
  input  logic [15:0] req0_data,
  input  logic [15:0] req1_data,
  input  logic        req0_wide,
  input  logic        req1_wide,
  output logic        req0_ack,
  output logic        req1_ack,
  input  logic        cfg_wr,
  input  logic [15:0] cfg_baud,
  output logic        trmt,
  output logic [7:0]  tx_data,
  input  logic        tx_done,
  output logic [15:0] baud,
  output logic        busy,
  output logic        grant,
  output logic        frm_done
);
  typedef enum logic [1:0] {IDLE, WAIT1, WAIT2} state_t;
  state_t state;
  logic last, wide_q, tx_done_q, pend_v, bc, sel, sel_wide, cfg_ok, upd_v;
  logic [7:0] lo_q;
  logic [15:0] pend, sel_data, upd;
  always_comb begin
    bc = tx_done & ~tx_done_q;
    sel = (req0 & req1) ? ~last : req1;
    sel_data = sel ? req1_data : req0_data;
    sel_wide = sel ? req1_wide : req0_wide;
    cfg_ok = cfg_wr & (cfg_baud != 16'd0);
    upd = cfg_ok ? cfg_baud : pend;
    upd_v = cfg_ok | pend_v;
  end
  // a write landing on an idle edge goes straight to baud so it shows up next cycle
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      trmt <= 1'b0;
      req0_ack <= 1'b0;
      req1_ack <= 1'b0;
      frm_done <= 1'b0;
      busy <= 1'b0;
      tx_data <= 8'h00;
      grant <= 1'b0;
      last <= 1'b1;
      baud <= BAUD_RST;
      pend <= BAUD_RST;
      pend_v <= 1'b0;
      tx_done_q <= 1'b0;
      wide_q <= 1'b0;
      lo_q <= 8'h00;
    end else begin
      tx_done_q <= tx_done;
      trmt <= 1'b0;
      req0_ack <= 1'b0;
      req1_ack <= 1'b0;
      frm_done <= 1'b0;
      if (cfg_ok) pend <= cfg_baud;
      if (state == IDLE && upd_v) begin
        baud <= upd;
        pend_v <= 1'b0;
      end else if (cfg_ok) pend_v <= 1'b1;
      case (state)
        IDLE: if (req0 | req1) begin
          grant <= sel;
          last <= sel;
          req0_ack <= ~sel;
          req1_ack <= sel;
          wide_q <= sel_wide;
          lo_q <= sel_data[7:0];
          tx_data <= sel_wide ? sel_data[15:8] : sel_data[7:0];
          trmt <= 1'b1;
          busy <= 1'b1;
          state <= WAIT1;
        end
        WAIT1: if (bc) begin
          if (wide_q) begin
            trmt <= 1'b1;
            tx_data <= lo_q;
            state <= WAIT2;
          end else begin
            frm_done <= 1'b1;
            busy <= 1'b0;
            state <= IDLE;
          end
        end
        WAIT2: if (bc) begin
          frm_done <= 1'b1;
          busy <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_uart_tx_sched.sv
// tb_uart_tx_sched: vector table, corner sequences and randomized frames against a frame-level model
module tb_uart_tx_sched;
  logic clk, rst, req0, req1, req0_wide, req1_wide, cfg_wr, tx_done;
  logic [15:0] req0_data, req1_data, cfg_baud;
  logic req0_ack, req1_ack, trmt, busy, grant, frm_done;
  logic [7:0] tx_data;
  logic [15:0] baud;
  int vectors = 0, miscompares = 0;
  int clr_dly = 0, byte_dly = 3;

  uart_tx_sched dut (
    .clk(clk), .rst(rst), .req0(req0), .req1(req1), .req0_data(req0_data), .req1_data(req1_data),
    .req0_wide(req0_wide), .req1_wide(req1_wide), .req0_ack(req0_ack), .req1_ack(req1_ack),
    .cfg_wr(cfg_wr), .cfg_baud(cfg_baud), .trmt(trmt), .tx_data(tx_data), .tx_done(tx_done),
    .baud(baud), .busy(busy), .grant(grant), .frm_done(frm_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // transmitter stand-in: done level stays high until clr_dly after trmt, then byte_dly to finish
  initial begin
    tx_done = 1'b1;
    forever begin
      @(negedge clk);
      if (trmt) begin
        repeat (clr_dly) @(negedge clk);
        tx_done = 1'b0;
        repeat (byte_dly) @(negedge clk);
        tx_done = 1'b1;
      end
    end
  end

  initial begin
    #5ms;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1);
  end

  typedef struct {
    logic r0, r1;
    logic [15:0] d0, d1;
    logic w0, w1;
    logic g;
    int n;
    logic [7:0] b0, b1;
  } vec_t;
  vec_t tbl[7];

  task automatic chk(input string n, input logic [15:0] a, input logic [15:0] e);
    vectors++;
    if (a !== e) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", n, a, e);
    end
  endtask

  task automatic wait_ack();
    int t = 0;
    do begin @(negedge clk); t++; end while (!(req0_ack | req1_ack) && t < 20);
  endtask

  task automatic run_frame(input logic r0, r1, input logic [15:0] d0, d1, input logic w0, w1,
                           input logic eg, input int en, input logic [7:0] b0, b1);
    int t;
    logic fell;
    @(negedge clk);
    req0 = r0; req1 = r1; req0_data = d0; req1_data = d1; req0_wide = w0; req1_wide = w1;
    wait_ack();
    chk("ack", {14'd0, req1_ack, req0_ack}, eg ? 16'd2 : 16'd1);
    chk("grant", {15'd0, grant}, {15'd0, eg});
    chk("trmt1", {15'd0, trmt}, 16'd1);
    chk("busy", {15'd0, busy}, 16'd1);
    chk("byte0", {8'd0, tx_data}, {8'd0, b0});
    req0 = 1'b0; req1 = 1'b0;
    if (en == 2) begin
      fell = 1'b0;
      t = 0;
      do begin @(negedge clk); t++; if (!tx_done) fell = 1'b1; end while (!trmt && !frm_done && t < 100);
      chk("trmt2", {15'd0, trmt}, 16'd1);
      chk("byte1", {8'd0, tx_data}, {8'd0, b1});
      chk("done_fell_first", {15'd0, fell}, 16'd1);
    end
    t = 0;
    do begin @(negedge clk); t++; end while (!frm_done && !trmt && t < 100);
    chk("frm_done", {14'd0, trmt, frm_done}, 16'd1);
    chk("idle", {15'd0, busy}, 16'd0);
  endtask

  initial begin
    logic mlast, g, w;
    logic [1:0] r;
    logic [15:0] d0, d1, dsel;
    int t, cnt;
    tbl[0] = '{1'b1, 1'b0, 16'hA55A, 16'h0000, 1'b1, 1'b0, 1'b0, 2, 8'hA5, 8'h5A};
    tbl[1] = '{1'b0, 1'b1, 16'h0000, 16'hFF3C, 1'b0, 1'b0, 1'b1, 1, 8'h3C, 8'h00};
    tbl[2] = '{1'b1, 1'b1, 16'h1234, 16'h5678, 1'b1, 1'b0, 1'b0, 2, 8'h12, 8'h34};
    tbl[3] = '{1'b1, 1'b1, 16'h00AB, 16'hCDEF, 1'b0, 1'b1, 1'b1, 2, 8'hCD, 8'hEF};
    tbl[4] = '{1'b1, 1'b1, 16'h0011, 16'h0022, 1'b0, 1'b0, 1'b0, 1, 8'h11, 8'h00};
    tbl[5] = '{1'b1, 1'b0, 16'hBEEF, 16'h0000, 1'b0, 1'b0, 1'b0, 1, 8'hEF, 8'h00};
    tbl[6] = '{1'b1, 1'b1, 16'h1111, 16'h2299, 1'b1, 1'b0, 1'b1, 1, 8'h99, 8'h00};
    rst = 1'b1; req0 = 1'b0; req1 = 1'b0; req0_data = '0; req1_data = '0;
    req0_wide = 1'b0; req1_wide = 1'b0; cfg_wr = 1'b0; cfg_baud = '0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("rst_trmt", {15'd0, trmt}, 16'd0);
    chk("rst_busy", {15'd0, busy}, 16'd0);
    chk("rst_acks", {14'd0, req1_ack, req0_ack}, 16'd0);
    chk("rst_frm_done", {15'd0, frm_done}, 16'd0);
    chk("rst_tx_data", {8'd0, tx_data}, 16'd0);
    chk("rst_grant", {15'd0, grant}, 16'd0);
    chk("rst_baud", baud, 16'd868);

    foreach (tbl[i])
      run_frame(tbl[i].r0, tbl[i].r1, tbl[i].d0, tbl[i].d1, tbl[i].w0, tbl[i].w1,
                tbl[i].g, tbl[i].n, tbl[i].b0, tbl[i].b1);

    // both held: grants alternate, re-grant lands the cycle after frm_done
    @(negedge clk);
    req0 = 1'b1; req1 = 1'b1; req0_data = 16'h0011; req1_data = 16'h0022; req0_wide = 1'b0; req1_wide = 1'b0;
    wait_ack();
    for (int i = 0; i < 4; i++) begin
      chk("alt_grant", {15'd0, grant}, i[15:0] & 16'd1);
      chk("alt_byte", {8'd0, tx_data}, i[0] ? 16'h0022 : 16'h0011);
      t = 0;
      do begin @(negedge clk); t++; end while (!frm_done && t < 100);
      chk("alt_frm_done", {15'd0, frm_done}, 16'd1);
      if (i == 3) begin
        req0 = 1'b0; req1 = 1'b0;
      end else begin
        @(negedge clk);
        chk("alt_ack_next", {15'd0, req0_ack | req1_ack}, 16'd1);
      end
    end

    // baud write mid-frame is deferred to idle; zero writes are dropped; idle writes are immediate
    @(negedge clk);
    req0 = 1'b1; req0_data = 16'h0077; req0_wide = 1'b0;
    wait_ack();
    req0 = 1'b0; cfg_wr = 1'b1; cfg_baud = 16'd20;
    @(negedge clk);
    cfg_wr = 1'b0;
    chk("baud_held_busy", baud, 16'd868);
    t = 0;
    do begin @(negedge clk); t++; end while (!frm_done && t < 100);
    chk("baud_frm_done", {15'd0, frm_done}, 16'd1);
    chk("baud_at_done", baud, 16'd868);
    @(negedge clk);
    chk("baud_applied", baud, 16'd20);
    cfg_wr = 1'b1; cfg_baud = 16'd0;
    @(negedge clk);
    cfg_wr = 1'b0;
    chk("baud_zero_ignored", baud, 16'd20);
    cfg_wr = 1'b1; cfg_baud = 16'd50;
    @(negedge clk);
    cfg_wr = 1'b0;
    chk("baud_idle_write", baud, 16'd50);

    // stale done level must not advance the sequencer
    clr_dly = 4;
    run_frame(1'b1, 1'b0, 16'hC3E1, 16'h0000, 1'b1, 1'b0, 1'b0, 2, 8'hC3, 8'hE1);
    clr_dly = 0;

    // reset while in WAIT2
    byte_dly = 10;
    @(negedge clk);
    req1 = 1'b1; req1_data = 16'hABCD; req1_wide = 1'b1;
    wait_ack();
    chk("rw2_grant", {15'd0, grant}, 16'd1);
    req1 = 1'b0;
    t = 0;
    do begin @(negedge clk); t++; end while (!trmt && t < 100);
    chk("rw2_trmt2", {15'd0, trmt}, 16'd1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("rw2_busy", {15'd0, busy}, 16'd0);
    chk("rw2_trmt", {15'd0, trmt}, 16'd0);
    chk("rw2_tx_data", {8'd0, tx_data}, 16'd0);
    chk("rw2_grant_rst", {15'd0, grant}, 16'd0);
    chk("rw2_baud", baud, 16'd868);
    cnt = 0;
    repeat (15) begin @(negedge clk); cnt += int'(frm_done); end
    chk("rw2_no_frm_done", cnt[15:0], 16'd0);
    byte_dly = 3;
    run_frame(1'b1, 1'b1, 16'h0042, 16'h0024, 1'b0, 1'b0, 1'b0, 1, 8'h42, 8'h00);

    // random frames against the round-robin frame model
    mlast = 1'b0;
    for (int i = 0; i < 40; i++) begin
      byte_dly = $urandom_range(2, 6);
      r = 2'($urandom_range(1, 3));
      d0 = 16'($urandom); d1 = 16'($urandom);
      req0_wide = 1'($urandom); req1_wide = 1'($urandom);
      g = (r == 2'b11) ? ~mlast : r[1];
      mlast = g;
      dsel = g ? d1 : d0;
      w = g ? req1_wide : req0_wide;
      run_frame(r[0], r[1], d0, d1, req0_wide, req1_wide, g, w ? 2 : 1,
                w ? dsel[15:8] : dsel[7:0], dsel[7:0]);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
